fir_mac_engine: RTL



---
 rtl/fir_mac_engine.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fir_mac_engine.sv
// fir_mac_engine
// Sequential multiply-accumulate engine for the lowpass FIR.
// Accepts one signed sample per handshake and writes it into a 64-entry
// circular delay line. It then walks the coefficient ROM over NTAPS
// addresses, accumulating sample x coefficient. Finally it emits one
// rounded, saturated output sample.
//
// Ports:
//   i_clock      single clock, all state updates on the rising edge
//   i_reset      synchronous, active-high; aborts any computation and clears history
//   i_in_valid   i_in_data holds a valid sample
//   i_in_data    input sample (signed, DATA_W)
//   o_in_ready   engine can accept a sample (IDLE only)
//   o_coef_addr  coefficient ROM address (0 outside MAC)
//   i_coef_q     ROM registered data for the address presented one cycle earlier
//   o_out_valid  one-cycle pulse when o_out_data is updated
//   o_out_data   filtered sample (signed, DATA_W), held until the next result
//   o_busy       high while a sample is being processed
module fir_mac_engine #(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int NTAPS      = 59,
  parameter int ADDR_W     = 7,
  parameter int DEPTH_LOG2 = 6,
  parameter int ACC_W      = 40,
  parameter int OUT_SHIFT  = 15
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic [ADDR_W-1:0] o_coef_addr,
  input  logic [COEF_W-1:0] i_coef_q,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_busy
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int PROD_W = DATA_W + COEF_W;

  // Half an output LSB, added before the arithmetic shift (round-half-up).
  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(1) << (OUT_SHIFT - 1);
  // Output range expressed at accumulator width for the saturation compare.
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic signed [DATA_W-1:0]     r_buf [DEPTH];
  logic        [DEPTH_LOG2-1:0] r_wp;
  logic        [DEPTH_LOG2-1:0] r_base;
  logic        [ADDR_W-1:0]     r_k;
  logic signed [DATA_W-1:0]     r_samp;
  logic signed [ACC_W-1:0]      r_acc;
  // Set in the cycle after an issue: r_samp and i_coef_q then form a pair.
  logic                         r_issue;
  logic                         r_out_valid;
  logic        [DATA_W-1:0]     r_out_data;

  logic        [DEPTH_LOG2-1:0] w_rd_idx;
  logic signed [COEF_W-1:0]     w_coef;
  logic signed [PROD_W-1:0]     w_prod;
  logic signed [ACC_W-1:0]      w_prod_ext;
  logic signed [ACC_W-1:0]      w_acc_next;
  logic signed [ACC_W-1:0]      w_biased;
  logic signed [ACC_W-1:0]      w_rounded;
  logic        [DATA_W-1:0]     w_sat;
  logic                         w_last_issue;

  // Newest sample sits at base; tap k reads k samples back, wrapping mod DEPTH.
  assign w_rd_idx     = r_base - r_k[DEPTH_LOG2-1:0];
  assign w_last_issue = (r_k == ADDR_W'(NTAPS - 1));

  // ---------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_in_valid)   w_state_next = S_MAC;
      S_MAC:   if (w_last_issue) w_state_next = S_DRAIN;
      S_DRAIN: w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Datapath: product, accumulate, round, saturate
  // ---------------------------------------------------------------
  assign w_coef     = i_coef_q;
  assign w_prod     = r_samp * w_coef;
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_acc_next = r_issue ? (r_acc + w_prod_ext) : r_acc;
  assign w_biased   = w_acc_next + ROUND_BIAS;
  assign w_rounded  = w_biased >>> OUT_SHIFT;

  always_comb begin
    w_sat = w_rounded[DATA_W-1:0];
    if (w_rounded > OUT_MAX) begin
      w_sat = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (w_rounded < OUT_MIN) begin
      w_sat = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end

  // ---------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_wp        <= '0;
      r_base      <= '0;
      r_k         <= '0;
      r_samp      <= '0;
      r_acc       <= '0;
      r_issue     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      // History is cleared so a restart behaves exactly like power-up.
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_state     <= w_state_next;
      r_issue     <= (r_state == S_MAC);
      // Result is registered as DRAIN completes, so it is visible in DONE.
      r_out_valid <= (r_state == S_DRAIN);
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_buf[r_wp] <= i_in_data;
            r_base      <= r_wp;
            r_wp        <= r_wp + DEPTH_LOG2'(1);
            r_acc       <= '0;
            r_k         <= '0;
          end
        end
        S_MAC: begin
          r_samp <= r_buf[w_rd_idx];
          r_k    <= r_k + ADDR_W'(1);
          r_acc  <= w_acc_next;
        end
        S_DRAIN: begin
          r_acc      <= w_acc_next;
          r_out_data <= w_sat;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  assign o_in_ready  = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  // Only addresses 0..NTAPS-1 ever leave the block; idle parks at 0.
  assign o_coef_addr = (r_state == S_MAC) ? r_k : '0;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;

endmodule
